// File: rtl/swizzle_cram_to_dram_pp.sv
// swizzle_cram_to_dram_pp
//
// Takes bit-serial compute-RAM words and transposes each DWIDTH x DWIDTH tile
// through two ping-pong register buffers. The transposed tile is issued as
// sequential writes to the DRAM memory controller. A run-time bypass mode
// forwards words one-for-one through a single output register. Back-pressure
// works in both directions.
//
// Ports
//   clk               clock
//   reset             asynchronous, active-high reset
//   bypass_en         1 = passthrough, 0 = transpose; latched only while idle
//   clear             synchronous flush of buffers, pending output and address
//   data_valid        ram_data_in carries a word this cycle
//   data_ready        block accepts a word this cycle
//   ram_data_in       compute-RAM word (one bit-slice row)
//   mem_ctrl_ready    controller accepts a write this cycle
//   mem_ctrl_data_out write data
//   mem_ctrl_addr     write address; increments on each completed write
//   mem_ctrl_we       write valid
//   busy              a buffer is non-empty or a write is pending
module swizzle_cram_to_dram_pp #(
  parameter int unsigned DWIDTH     = 40,
  parameter int unsigned AWIDTH     = 9,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bypass_en,
  input  logic              clear,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic [DWIDTH-1:0] ram_data_in,
  input  logic              mem_ctrl_ready,
  output logic [DWIDTH-1:0] mem_ctrl_data_out,
  output logic [AWIDTH-1:0] mem_ctrl_addr,
  output logic              mem_ctrl_we,
  output logic              busy
);

  localparam int unsigned       PW        = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [PW-1:0]     LastRow   = PW'(DWIDTH - 1);
  localparam logic [AWIDTH-1:0] StartAddr = AWIDTH'(START_ADDR);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull, StDraining} buf_state_e;

  buf_state_e        state_q [2];
  buf_state_e        state_d [2];
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     drain_ptr_q, drain_ptr_d;
  logic              fill_sel_q, fill_sel_d;
  logic              mode_q, mode_d;  // 1 = bypass
  logic [DWIDTH-1:0] out_data_q, out_data_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic              we_q, we_d;

  // Tile storage; contents are only meaningful under the buffer state, so no reset.
  logic [DWIDTH-1:0] tile_q [2][DWIDTH];

  logic              write_done;
  logic              out_free;
  logic              accept;
  logic              drain_avail;
  logic              drain_sel;
  logic              drain_go;
  logic              drain_last;
  logic [DWIDTH-1:0] drain_word;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q[0]  <= StEmpty;
      state_q[1]  <= StEmpty;
      fill_ptr_q  <= '0;
      drain_ptr_q <= '0;
      fill_sel_q  <= 1'b0;
      mode_q      <= 1'b0;
      out_data_q  <= '0;
      addr_q      <= StartAddr;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      fill_sel_q  <= fill_sel_d;
      mode_q      <= mode_d;
      out_data_q  <= out_data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!mode_q && accept) begin
      tile_q[fill_sel_q][fill_ptr_q] <= ram_data_in;
    end
  end

  // Output / handshake decode
  always_comb begin
    write_done  = we_q & mem_ctrl_ready;
    out_free    = ~we_q | mem_ctrl_ready;
    drain_avail = 1'b1;
    drain_sel   = 1'b0;
    // A buffer already draining keeps the port; otherwise ping wins among FULL buffers.
    if (state_q[0] == StDraining) begin
      drain_sel = 1'b0;
    end else if (state_q[1] == StDraining) begin
      drain_sel = 1'b1;
    end else if (state_q[0] == StFull) begin
      drain_sel = 1'b0;
    end else if (state_q[1] == StFull) begin
      drain_sel = 1'b1;
    end else begin
      drain_avail = 1'b0;
    end
    drain_go   = ~mode_q & drain_avail & out_free;
    drain_last = drain_go & (drain_ptr_q == LastRow);

    if (mode_q) begin
      data_ready = out_free;
    end else begin
      // The fill buffer may be the one emitting its last word this cycle; it is
      // free at the same edge, so a new row 0 may be taken into it.
      data_ready = (state_q[fill_sel_q] == StEmpty) || (state_q[fill_sel_q] == StFilling) ||
                   (drain_last && (drain_sel == fill_sel_q));
    end
    accept = data_valid & data_ready;
    busy   = we_q | (state_q[0] != StEmpty) | (state_q[1] != StEmpty);
  end

  // Column drain_ptr of the selected tile: bit i comes from row i.
  always_comb begin
    drain_word = '0;
    for (int i = 0; i < DWIDTH; i++) begin
      drain_word[i] = tile_q[drain_sel][i][drain_ptr_q];
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    fill_sel_d  = fill_sel_q;
    mode_d      = mode_q;
    out_data_d  = out_data_q;
    addr_d      = addr_q;
    we_d        = we_q;

    if (write_done) begin
      we_d   = 1'b0;
      addr_d = addr_q + 1'b1;
    end

    if (!busy && !accept) begin
      mode_d = bypass_en;
    end

    if (mode_q) begin
      if (accept) begin
        out_data_d = ram_data_in;
        we_d       = 1'b1;
      end
    end else begin
      if (drain_go) begin
        out_data_d = drain_word;
        we_d       = 1'b1;
        if (drain_last) begin
          state_d[drain_sel] = StEmpty;
          drain_ptr_d        = '0;
        end else begin
          state_d[drain_sel] = StDraining;
          drain_ptr_d        = drain_ptr_q + 1'b1;
        end
      end
      // Applied after the drain so a refill of a just-emptied buffer wins.
      if (accept) begin
        if (fill_ptr_q == LastRow) begin
          state_d[fill_sel_q] = StFull;
          fill_ptr_d          = '0;
          fill_sel_d          = ~fill_sel_q;
        end else begin
          state_d[fill_sel_q] = StFilling;
          fill_ptr_d          = fill_ptr_q + 1'b1;
        end
      end
    end

    if (clear) begin
      state_d[0]  = StEmpty;
      state_d[1]  = StEmpty;
      fill_ptr_d  = '0;
      drain_ptr_d = '0;
      fill_sel_d  = 1'b0;
      out_data_d  = '0;
      we_d        = 1'b0;
      addr_d      = StartAddr;
    end
  end

  assign mem_ctrl_data_out = out_data_q;
  assign mem_ctrl_addr     = addr_q;
  assign mem_ctrl_we       = we_q;

endmodule

// File: tb/tb_swizzle_cram_to_dram_pp.sv
// Self-checking bench for swizzle_cram_to_dram_pp. A queue-based reference model
// derives the expected write stream (data and address) from accepted words; a
// single negedge process compares every completed write against it.
module tb_swizzle_cram_to_dram_pp;

  localparam int DW = 40;
  localparam int AW = 9;

  logic          clk, rst, bypass_en, clear, data_valid, mem_ctrl_ready;
  logic [DW-1:0] ram_data_in, mem_ctrl_data_out;
  logic [AW-1:0] mem_ctrl_addr;
  logic          mem_ctrl_we, data_ready, busy;

  // Second instance for the address wrap case
  logic          w_bypass, w_clear, w_valid, w_ready, w_mready, w_we, w_busy;
  logic [DW-1:0] w_din, w_dout;
  logic [AW-1:0] w_addr;

  swizzle_cram_to_dram_pp #(.DWIDTH(DW), .AWIDTH(AW), .START_ADDR(0)) dut (
    .clk(clk), .reset(rst), .bypass_en(bypass_en), .clear(clear),
    .data_valid(data_valid), .data_ready(data_ready), .ram_data_in(ram_data_in),
    .mem_ctrl_ready(mem_ctrl_ready), .mem_ctrl_data_out(mem_ctrl_data_out),
    .mem_ctrl_addr(mem_ctrl_addr), .mem_ctrl_we(mem_ctrl_we), .busy(busy)
  );

  swizzle_cram_to_dram_pp #(.DWIDTH(DW), .AWIDTH(AW), .START_ADDR(510)) dut_w (
    .clk(clk), .reset(rst), .bypass_en(w_bypass), .clear(w_clear),
    .data_valid(w_valid), .data_ready(w_ready), .ram_data_in(w_din),
    .mem_ctrl_ready(w_mready), .mem_ctrl_data_out(w_dout),
    .mem_ctrl_addr(w_addr), .mem_ctrl_we(w_we), .busy(w_busy)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model state
  logic [DW-1:0] rows[$];
  logic [DW-1:0] expq[$];
  logic [DW-1:0] log_data[$];
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] wlog_data[$];
  logic [AW-1:0] wlog_addr[$];
  logic [AW-1:0] exp_addr = '0;
  bit            model_bypass = 0;
  bit            hold_prev = 0, acc_prev_bp = 0, due_valid = 0, watch = 0;
  int            due_cyc = 0, stall_cnt = 0;
  logic [DW-1:0] prev_data, prev_word, due_word, m_e, m_w;
  logic [AW-1:0] prev_addr;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [DW-1:0] rand_word();
    return {8'($urandom()), $urandom()};
  endfunction

  function automatic logic [DW-1:0] column(input int j);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < DW; i++) w[i] = rows[i][j];
    return w;
  endfunction

  // Compare process and model update
  always @(negedge clk) begin
    if (rst) begin
      rows.delete(); expq.delete();
      exp_addr = '0; hold_prev = 0; acc_prev_bp = 0; due_valid = 0;
    end else begin
      if (hold_prev) begin
        check("hold_we", 64'(mem_ctrl_we), 64'(1));
        check("hold_data", 64'(mem_ctrl_data_out), 64'(prev_data));
        check("hold_addr", 64'(mem_ctrl_addr), 64'(prev_addr));
      end
      if (acc_prev_bp) begin
        check("bypass_latency_we", 64'(mem_ctrl_we), 64'(1));
        check("bypass_latency_data", 64'(mem_ctrl_data_out), 64'(prev_word));
      end
      if (due_valid && cyc == due_cyc) begin
        check("tile_latency_we", 64'(mem_ctrl_we), 64'(1));
        check("tile_latency_data", 64'(mem_ctrl_data_out), 64'(due_word));
        due_valid = 0;
      end
      hold_prev   = mem_ctrl_we && !mem_ctrl_ready;
      prev_data   = mem_ctrl_data_out;
      prev_addr   = mem_ctrl_addr;
      acc_prev_bp = 0;
      if (clear) begin
        rows.delete(); expq.delete();
        exp_addr = '0; hold_prev = 0; due_valid = 0;
      end else begin
        if (mem_ctrl_we && mem_ctrl_ready) begin
          if (expq.size() == 0) begin
            timeout_fail("unexpected_write");
          end else begin
            m_e = expq.pop_front();
            check("write_data", 64'(mem_ctrl_data_out), 64'(m_e));
            check("write_addr", 64'(mem_ctrl_addr), 64'(exp_addr));
          end
          exp_addr = exp_addr + 1'b1;
          log_data.push_back(mem_ctrl_data_out);
          log_addr.push_back(mem_ctrl_addr);
        end
        if (data_valid && data_ready) begin
          if (model_bypass) begin
            expq.push_back(ram_data_in);
            acc_prev_bp = 1;
            prev_word   = ram_data_in;
          end else begin
            rows.push_back(ram_data_in);
            if (rows.size() == DW) begin
              if (expq.size() == 0) begin
                due_valid = 1;
                due_cyc   = cyc + 2;
                due_word  = column(0);
              end
              for (int j = 0; j < DW; j++) expq.push_back(column(j));
              rows.delete();
            end
          end
        end
        if (watch && data_valid && !data_ready) stall_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && w_we && w_mready) begin
      wlog_data.push_back(w_dout);
      wlog_addr.push_back(w_addr);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    int t = 0;
    data_valid  = 1'b1;
    ram_data_in = w;
    @(negedge clk);
    while (!data_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!data_ready) timeout_fail("accept");
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((expq.size() != 0 || busy) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (expq.size() != 0 || busy) timeout_fail("idle");
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input bit b);
    wait_idle();
    bypass_en    = b;
    model_bypass = b;
    step(2);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  bit rnd_on;

  initial begin
    rst = 1'b1; bypass_en = 1'b0; clear = 1'b0; data_valid = 1'b0;
    ram_data_in = '0; mem_ctrl_ready = 1'b1;
    w_bypass = 1'b1; w_clear = 1'b0; w_valid = 1'b0; w_din = '0; w_mready = 1'b1;
    step(3);
    check("reset_we", 64'(mem_ctrl_we), 64'(0));
    check("reset_addr", 64'(mem_ctrl_addr), 64'(0));
    check("reset_data", 64'(mem_ctrl_data_out), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(data_ready), 64'(1));
    rst = 1'b0;
    step(2);

    // Bypass: three words, aligned writes at 0,1,2
    set_mode(1);
    log_data.delete(); log_addr.delete();
    send_word(40'hA5A5A5A5A5);
    send_word(40'h5A5A5A5A5A);
    send_word(40'hFFFFFFFFFF);
    wait_idle();
    check("bp_count", 64'(log_data.size()), 64'(3));
    if (log_data.size() == 3) begin
      check("bp_d0", 64'(log_data[0]), 64'h00A5A5A5A5A5);
      check("bp_d1", 64'(log_data[1]), 64'h005A5A5A5A5A);
      check("bp_d2", 64'(log_data[2]), 64'h00FFFFFFFFFF);
      check("bp_a0", 64'(log_addr[0]), 64'(0));
      check("bp_a2", 64'(log_addr[2]), 64'(2));
    end

    // Transpose: identity tile
    set_mode(0);
    pulse_clear();
    log_data.delete(); log_addr.delete();
    for (int k = 0; k < DW; k++) send_word(40'd1 << k);
    wait_idle();
    check("id_count", 64'(log_data.size()), 64'(40));
    if (log_data.size() == 40) begin
      check("id_w0", 64'(log_data[0]), 64'h1);
      check("id_w17", 64'(log_data[17]), 64'h20000);
      check("id_w39", 64'(log_data[39]), 64'h8000000000);
      check("id_a0", 64'(log_addr[0]), 64'(0));
      check("id_a39", 64'(log_addr[39]), 64'(39));
    end

    // Three back-to-back random tiles, no bubbles; bypass_en wiggles while busy
    log_data.delete(); log_addr.delete();
    stall_cnt = 0; watch = 1;
    for (int k = 0; k < 3 * DW; k++) begin
      if (k == 50) bypass_en = 1'b1;
      if (k == 100) bypass_en = 1'b0;
      send_word(rand_word());
    end
    watch = 0;
    wait_idle();
    check("b2b_bubbles", 64'(stall_cnt), 64'(0));
    check("b2b_count", 64'(log_data.size()), 64'(120));
    if (log_data.size() == 120) check("b2b_last_addr", 64'(log_addr[119]), 64'(159));

    // Controller stalls 50 cycles mid-drain
    log_data.delete(); log_addr.delete();
    stall_cnt = 0; watch = 1;
    fork
      begin
        for (int k = 0; k < 3 * DW; k++) send_word(rand_word());
      end
      begin
        int t = 0;
        while (log_data.size() < 10 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        if (log_data.size() < 10) timeout_fail("stall_start");
        @(posedge clk);
        #1;
        mem_ctrl_ready = 1'b0;
        step(50);
        check("stall_we_held", 64'(mem_ctrl_we), 64'(1));
        mem_ctrl_ready = 1'b1;
      end
    join
    watch = 0;
    wait_idle();
    check("stall_ready_dropped", 64'(stall_cnt > 0), 64'(1));
    check("stall_count", 64'(log_data.size()), 64'(120));

    // Partial tile held, then cleared, then a full tile from START_ADDR
    pulse_clear();
    log_data.delete(); log_addr.delete();
    for (int k = 0; k < 20; k++) send_word(rand_word());
    step(60);
    check("partial_no_write", 64'(log_data.size()), 64'(0));
    check("partial_busy", 64'(busy), 64'(1));
    pulse_clear();
    step(1);
    check("clear_busy", 64'(busy), 64'(0));
    for (int k = 0; k < DW; k++) send_word(rand_word());
    wait_idle();
    check("clear_count", 64'(log_data.size()), 64'(40));
    if (log_data.size() == 40) begin
      check("clear_a0", 64'(log_addr[0]), 64'(0));
      check("clear_a39", 64'(log_addr[39]), 64'(39));
    end

    // Random valid/ready in both modes
    rnd_on = 1;
    fork
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1;
          mem_ctrl_ready = ($urandom_range(0, 9) < 7);
        end
        mem_ctrl_ready = 1'b1;
      end
      begin
        set_mode(1);
        for (int k = 0; k < 30; k++) begin
          step($urandom_range(0, 2));
          send_word(rand_word());
        end
        set_mode(0);
        for (int k = 0; k < 3 * DW; k++) begin
          step($urandom_range(0, 1));
          send_word(rand_word());
        end
        wait_idle();
        rnd_on = 0;
      end
    join
    step(2);

    // Asynchronous reset in the middle of a drain
    log_data.delete(); log_addr.delete();
    for (int k = 0; k < DW; k++) send_word(rand_word());
    begin
      int t = 0;
      while (log_data.size() < 5 && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (log_data.size() < 5) timeout_fail("drain_start");
    end
    #2;
    rst = 1'b1;
    #1;
    check("async_we", 64'(mem_ctrl_we), 64'(0));
    check("async_addr", 64'(mem_ctrl_addr), 64'(0));
    check("async_busy", 64'(busy), 64'(0));
    step(2);
    rst = 1'b0;
    step(3);
    check("post_reset_we", 64'(mem_ctrl_we), 64'(0));
    check("post_reset_busy", 64'(busy), 64'(0));

    // Address wrap on the START_ADDR = 510 instance, bypass mode
    begin
      logic [DW-1:0] wd [4];
      for (int k = 0; k < 4; k++) wd[k] = rand_word();
      for (int k = 0; k < 4; k++) begin
        w_din   = wd[k];
        w_valid = 1'b1;
        step(1);
      end
      w_valid = 1'b0;
      step(4);
      check("wrap_count", 64'(wlog_addr.size()), 64'(4));
      if (wlog_addr.size() == 4) begin
        check("wrap_a0", 64'(wlog_addr[0]), 64'(510));
        check("wrap_a1", 64'(wlog_addr[1]), 64'(511));
        check("wrap_a2", 64'(wlog_addr[2]), 64'(0));
        check("wrap_a3", 64'(wlog_addr[3]), 64'(1));
        for (int k = 0; k < 4; k++) check("wrap_data", 64'(wlog_data[k]), 64'(wd[k]));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
